// File: rtl/fetch_unit.sv
// Instruction fetch unit: requests one word at a time from instruction memory,
// holds it for the control unit and computes the next PC when it is consumed.
module fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  pc_control,
  input  logic [25:0] jump_target,
  input  logic [31:0] jr_target,
  input  logic [15:0] branch_offset,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic [31:0] count_q, count_d;
  logic [31:0] next_pc;
  logic [31:0] branch_disp;
  logic        unused_jr_low;

  // Register-jump targets are forced word-aligned, so the low bits never matter.
  assign unused_jr_low = ^jr_target[1:0];

  assign pc_plus4    = pc_q + 32'd4;
  assign branch_disp = {{14{branch_offset[15]}}, branch_offset, 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    case (pc_control)
      4'b0001: next_pc = {pc_plus4[31:28], jump_target, 2'b00};
      4'b0010: next_pc = {jr_target[31:2], 2'b00};
      4'b0011: next_pc = pc_plus4 + branch_disp;
      default: next_pc = pc_plus4;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_VECTOR;
      instr_q <= 32'h0000_0000;
      valid_q <= 1'b0;
      count_q <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  // pc_control is only looked at on the edge that consumes the held instruction.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    count_d = count_q;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (!stall) begin
          pc_d    = next_pc;
          valid_d = 1'b0;
          count_d = count_q + 32'd1;
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign imem_req    = (state_q == REQ);
  assign imem_addr   = pc_q;
  assign instruction = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign instr_count = count_q;

endmodule
